// File: rtl/jogo_pkg.sv
// Shared definitions for the memory game datapath: replay directions and
// the default game dimensions.
package jogo_pkg;

  // Replay direction of a round
  localparam logic MODO_DIRETO  = 1'b0;
  localparam logic MODO_REVERSO = 1'b1;

  // Default game size: last round index and counter width
  localparam int M_PADRAO = 32;
  localparam int N_PADRAO = 6;

endpackage

// File: rtl/contador_updown_sat.sv
// N-bit up/down counter with synchronous load that stops at its terminal
// value instead of wrapping. Terminal is `limite` counting up, 0 counting down.
module contador_updown_sat
  import jogo_pkg::*;
#(
  parameter int N = N_PADRAO
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] valor_load,
  input  logic         en,
  input  logic         dir,
  input  logic [N-1:0] limite,
  output logic [N-1:0] contagem,
  output logic         terminal
);

  // Terminal flag follows the current direction
  always_comb begin
    terminal = 1'b0;
    if (dir == MODO_REVERSO) terminal = (contagem == '0);
    else                     terminal = (contagem == limite);
  end

  // Load wins over counting; counting stops once terminal is reached
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      contagem <= '0;
    end else if (load) begin
      contagem <= valor_load;
    end else if (en && !terminal) begin
      if (dir == MODO_REVERSO) contagem <= contagem - 1'b1;
      else                     contagem <= contagem + 1'b1;
    end
  end

endmodule

// File: rtl/contador_rodadas_jogadas.sv
// Round/move counter for the memory game: holds the round limit, the move
// index inside the round (sequence memory address), the active player and
// the replay direction latched at each round start.
module contador_rodadas_jogadas
  import jogo_pkg::*;
#(
  parameter int M  = M_PADRAO,
  parameter int N  = N_PADRAO,
  parameter int P  = 2,
  parameter int PW = 1
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          zera,
  input  logic          carrega,
  input  logic [N-1:0]  valor_carga,
  input  logic          avanca_rodada,
  input  logic          conta,
  input  logic          modo_reverso,
  output logic [N-1:0]  jogada,
  output logic [N-1:0]  rodada,
  output logic [PW-1:0] jogador,
  output logic          modo_atual,
  output logic          fim_rodada,
  output logic          fim_jogo,
  output logic          rodada_concluida
);

  // Reject parameter sets the counters cannot represent
  if ((1 << N) <= M) begin : g_chk_n
    $error("contador_rodadas_jogadas: 2**N must exceed M");
  end
  if (P < 1 || (1 << PW) < P) begin : g_chk_p
    $error("contador_rodadas_jogadas: need P >= 1 and 2**PW >= P");
  end

  localparam logic [N-1:0]  M_N      = N'(M);
  localparam logic [PW-1:0] ULTIMO_P = PW'(P - 1);

  // Decoded commands: only the highest-priority one is acted upon
  logic         cmd_carrega, cmd_avanca, avanca_ok, cmd_conta;
  logic         carrega_jogada;
  logic [N-1:0] carga_sat, valor_jogada, proximo, alvo;

  // Priority decode and start value of the move counter
  always_comb begin
    cmd_carrega    = !zera && carrega;
    cmd_avanca     = !zera && !carrega && avanca_rodada;
    avanca_ok      = cmd_avanca && (rodada < M_N);
    cmd_conta      = !zera && !carrega && !avanca_rodada && conta;
    carga_sat      = (valor_carga > M_N) ? M_N : valor_carga;
    carrega_jogada = zera || cmd_carrega || avanca_ok;
    valor_jogada   = '0;
    if (!zera && modo_reverso == MODO_REVERSO) begin
      if (cmd_carrega) valor_jogada = carga_sat;
      else             valor_jogada = rodada + 1'b1;
    end
  end

  contador_updown_sat #(.N(N)) u_jogada (
    .clock      (clock),
    .rst        (rst),
    .load       (carrega_jogada),
    .valor_load (valor_jogada),
    .en         (cmd_conta),
    .dir        (modo_atual),
    .limite     (rodada),
    .contagem   (jogada),
    .terminal   (fim_rodada)
  );

  // Next move index and terminal value, used to predict the end-of-round pulse
  always_comb begin
    proximo  = (modo_atual == MODO_REVERSO) ? jogada - 1'b1 : jogada + 1'b1;
    alvo     = (modo_atual == MODO_REVERSO) ? '0 : rodada;
    fim_jogo = (rodada == M_N) && fim_rodada;
  end

  // Round limit, player, latched direction and the round-complete pulse
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rodada           <= '0;
      jogador          <= '0;
      modo_atual       <= MODO_DIRETO;
      rodada_concluida <= 1'b0;
    end else begin
      rodada_concluida <= cmd_conta && !fim_rodada && (proximo == alvo);
      if (zera) begin
        rodada     <= '0;
        jogador    <= '0;
        modo_atual <= MODO_DIRETO;
      end else if (cmd_carrega) begin
        rodada     <= carga_sat;
        jogador    <= '0;
        modo_atual <= modo_reverso;
      end else if (avanca_ok) begin
        rodada     <= rodada + 1'b1;
        jogador    <= (jogador == ULTIMO_P) ? '0 : jogador + 1'b1;
        modo_atual <= modo_reverso;
      end
    end
  end

endmodule

// File: tb/tb_contador_rodadas_jogadas.sv
// Directed bench for contador_rodadas_jogadas with M=3, N=2, P=2, PW=1.
module tb_contador_rodadas_jogadas;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       zera = 1'b0, carrega = 1'b0, avanca_rodada = 1'b0;
  logic       conta = 1'b0, modo_reverso = 1'b0;
  logic [1:0] valor_carga = '0;
  logic [1:0] jogada, rodada;
  logic [0:0] jogador;
  logic       modo_atual, fim_rodada, fim_jogo, rodada_concluida;

  int checks = 0;
  int errors = 0;

  contador_rodadas_jogadas #(.M(3), .N(2), .P(2), .PW(1)) dut (
    .clock            (clock),
    .rst              (rst),
    .zera             (zera),
    .carrega          (carrega),
    .valor_carga      (valor_carga),
    .avanca_rodada    (avanca_rodada),
    .conta            (conta),
    .modo_reverso     (modo_reverso),
    .jogada           (jogada),
    .rodada           (rodada),
    .jogador          (jogador),
    .modo_atual       (modo_atual),
    .fim_rodada       (fim_rodada),
    .fim_jogo         (fim_jogo),
    .rodada_concluida (rodada_concluida)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       z, c;
    logic [1:0] vc;
    logic       a, k, mr;
    logic [1:0] ej, er;
    logic       ep, em, efr, efj, ec;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nome, input int idx, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", nome, idx, got, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [1:0] ej, input logic [1:0] er, input logic ep,
                           input logic em, input logic efr, input logic efj, input logic ec);
    check("jogada", idx, {6'd0, jogada}, {6'd0, ej});
    check("rodada", idx, {6'd0, rodada}, {6'd0, er});
    check("jogador", idx, {7'd0, jogador}, {7'd0, ep});
    check("modo_atual", idx, {7'd0, modo_atual}, {7'd0, em});
    check("fim_rodada", idx, {7'd0, fim_rodada}, {7'd0, efr});
    check("fim_jogo", idx, {7'd0, fim_jogo}, {7'd0, efj});
    check("rodada_concluida", idx, {7'd0, rodada_concluida}, {7'd0, ec});
  endtask

  task automatic idle_inputs();
    zera = 0; carrega = 0; valor_carga = 0; avanca_rodada = 0; conta = 0; modo_reverso = 0;
  endtask

  initial begin
    //              z  c  vc a  k  mr  ej er p  m  fr fj cc
    // Three round starts, then a fourth at the last round is ignored
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0});
    // Forward round 2: counts 1,2 then saturates; single pulse
    vecs.push_back('{0, 1, 2, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 2, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 2, 2, 0, 0, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 2, 2, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 1, 0, 0});
    // Reverse round started from round 1; modo_reverso toggled mid-round
    vecs.push_back('{0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 0, 1, 2, 2, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 2, 1, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 1, 0, 2, 1, 1, 1, 0, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 0, 2, 1, 1, 1, 0, 0});
    // Last round forward: end of game, then saturation with no pulse
    vecs.push_back('{0, 1, 3, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 2, 3, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 3, 3, 0, 0, 1, 1, 1});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 3, 3, 0, 0, 1, 1, 0});
    // Reverse load starts at the loaded round
    vecs.push_back('{0, 1, 2, 0, 0, 1, 2, 2, 0, 1, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 2, 0, 1, 0, 0, 0});
    // Priority: carrega over avanca_rodada, zera over conta, avanca over conta
    vecs.push_back('{0, 0, 0, 1, 0, 0, 0, 3, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0});

    // Reset state
    repeat (2) @(posedge clock);
    #2 rst = 0;
    #1 check_all(-1, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clock); #1;
    check_all(0, 0, 0, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      zera = vecs[i].z; carrega = vecs[i].c; valor_carga = vecs[i].vc;
      avanca_rodada = vecs[i].a; conta = vecs[i].k; modo_reverso = vecs[i].mr;
      @(posedge clock); #1;
      check_all(i + 1, vecs[i].ej, vecs[i].er, vecs[i].ep, vecs[i].em,
                vecs[i].efr, vecs[i].efj, vecs[i].ec);
    end
    idle_inputs();

    // Async reset between edges in the middle of round 2 (jogada=1)
    carrega = 1; valor_carga = 2;
    @(posedge clock); #1;
    idle_inputs(); conta = 1;
    @(posedge clock); #1;
    idle_inputs();
    check_all(100, 1, 2, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1 check_all(101, 0, 0, 0, 0, 1, 0, 0);
    #3 rst = 0;
    @(posedge clock); #1;
    check_all(102, 0, 0, 0, 0, 1, 0, 0);

    // Async reset kills a pending round-complete pulse
    carrega = 1; valor_carga = 1;
    @(posedge clock); #1;
    idle_inputs(); conta = 1;
    @(posedge clock); #1;
    idle_inputs();
    check_all(103, 1, 1, 0, 0, 1, 0, 1);
    #1 rst = 1;
    #1 check_all(104, 0, 0, 0, 0, 1, 0, 0);
    #2 rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: time limit reached before end of test");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
